// File: rtl/axi_req_arbiter.sv
// Single-outstanding arbiter from NR_PORTS cache request ports onto one AXI adapter port.
// Define AXI_ARB_ROUND_ROBIN_EN for round-robin selection; fixed lowest-index priority otherwise.
module axi_req_arbiter #(
  parameter int unsigned NR_PORTS       = 3,
  parameter int unsigned DATA_WIDTH     = 256,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4
) (
  input  logic                                                         clk_i,
  input  logic                                                         rst_ni,
  input  logic [NR_PORTS-1:0]                                          req_i,
  input  logic [NR_PORTS-1:0]                                          type_i,
  input  logic [NR_PORTS-1:0][63:0]                                    addr_i,
  input  logic [NR_PORTS-1:0]                                          we_i,
  input  logic [NR_PORTS-1:0][DATA_WIDTH/AXI_DATA_WIDTH-1:0][AXI_DATA_WIDTH-1:0] wdata_i,
  input  logic [NR_PORTS-1:0][DATA_WIDTH/8-1:0]                        be_i,
  input  logic [NR_PORTS-1:0][1:0]                                     size_i,
  input  logic [NR_PORTS-1:0][AXI_ID_WIDTH-1:0]                        id_i,
  output logic [NR_PORTS-1:0]                                          gnt_o,
  output logic [NR_PORTS-1:0]                                          valid_o,
  output logic [DATA_WIDTH-1:0]                                        rdata_o,
  output logic [AXI_ID_WIDTH-1:0]                                      rid_o,
  output logic                                                         ad_req_o,
  output logic                                                         ad_type_o,
  output logic [63:0]                                                  ad_addr_o,
  output logic                                                         ad_we_o,
  output logic [DATA_WIDTH/AXI_DATA_WIDTH-1:0][AXI_DATA_WIDTH-1:0]     ad_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                                      ad_be_o,
  output logic [1:0]                                                   ad_size_o,
  output logic [AXI_ID_WIDTH-1:0]                                      ad_id_o,
  input  logic                                                         ad_gnt_i,
  input  logic                                                         ad_valid_i,
  input  logic [DATA_WIDTH-1:0]                                        ad_rdata_i,
  input  logic [AXI_ID_WIDTH-1:0]                                      ad_id_i
);

  localparam int unsigned SEL_W = $clog2(NR_PORTS);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] win_idx;
  logic             win_found;
  logic             win_valid;

  assign win_valid = |req_i;

`ifdef AXI_ARB_ROUND_ROBIN_EN
  logic [SEL_W-1:0] rr_q;

  // Scan cyclically starting at rr_q; the first requester found wins.
  always_comb begin
    int unsigned p;
    logic [SEL_W-1:0] pi;
    p         = 0;
    pi        = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned k = 0; k < NR_PORTS; k++) begin
      p  = (int'(rr_q) + k) % NR_PORTS;
      pi = SEL_W'(p);
      if (!win_found && req_i[pi]) begin
        win_found = 1'b1;
        win_idx   = pi;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (state_q == REQ && ad_gnt_i) begin
      rr_q <= (sel_q == SEL_W'(NR_PORTS - 1)) ? '0 : sel_q + 1'b1;
    end
  end
`else
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned k = 0; k < NR_PORTS; k++) begin
      if (!win_found && req_i[SEL_W'(k)]) begin
        win_found = 1'b1;
        win_idx   = SEL_W'(k);
      end
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    ad_req_o = 1'b0;
    gnt_o    = '0;
    valid_o  = '0;
    rdata_o  = '0;
    rid_o    = '0;
    unique case (state_q)
      IDLE: begin
        if (win_valid) state_d = REQ;
      end
      REQ: begin
        ad_req_o = 1'b1;
        if (ad_gnt_i) begin
          gnt_o[sel_q] = 1'b1;
          state_d      = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // Response fields are gated so they read zero outside a completion.
        if (ad_valid_i) begin
          valid_o[sel_q] = 1'b1;
          rdata_o        = ad_rdata_i;
          rid_o          = ad_id_i;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      ad_type_o  <= 1'b0;
      ad_addr_o  <= '0;
      ad_we_o    <= 1'b0;
      ad_wdata_o <= '0;
      ad_be_o    <= '0;
      ad_size_o  <= '0;
      ad_id_o    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && win_valid) begin
        sel_q      <= win_idx;
        ad_type_o  <= type_i[win_idx];
        ad_addr_o  <= addr_i[win_idx];
        ad_we_o    <= we_i[win_idx];
        ad_wdata_o <= wdata_i[win_idx];
        ad_be_o    <= be_i[win_idx];
        ad_size_o  <= size_i[win_idx];
        ad_id_o    <= id_i[win_idx];
      end
    end
  end

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Self-checking bench for axi_req_arbiter: directed test-plan steps followed by random traffic
// checked against a transaction-level model of the arbitration rule.
module tb_axi_req_arbiter;

  logic                  clk;
  logic                  rst_ni;
  logic [2:0]            req_i;
  logic [2:0]            type_i;
  logic [2:0][63:0]      addr_i;
  logic [2:0]            we_i;
  logic [2:0][3:0][63:0] wdata_i;
  logic [2:0][31:0]      be_i;
  logic [2:0][1:0]       size_i;
  logic [2:0][3:0]       id_i;
  logic [2:0]            gnt_o;
  logic [2:0]            valid_o;
  logic [255:0]          rdata_o;
  logic [3:0]            rid_o;
  logic                  ad_req_o;
  logic                  ad_type_o;
  logic [63:0]           ad_addr_o;
  logic                  ad_we_o;
  logic [3:0][63:0]      ad_wdata_o;
  logic [31:0]           ad_be_o;
  logic [1:0]            ad_size_o;
  logic [3:0]            ad_id_o;
  logic                  ad_gnt_i;
  logic                  ad_valid_i;
  logic [255:0]          ad_rdata_i;
  logic [3:0]            ad_id_i;

  int checks = 0;
  int errors = 0;
  int rr_ptr = 0;

  axi_req_arbiter #(
    .NR_PORTS(3),
    .DATA_WIDTH(256),
    .AXI_DATA_WIDTH(64),
    .AXI_ID_WIDTH(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_i(req_i), .type_i(type_i), .addr_i(addr_i), .we_i(we_i),
    .wdata_i(wdata_i), .be_i(be_i), .size_i(size_i), .id_i(id_i),
    .gnt_o(gnt_o), .valid_o(valid_o), .rdata_o(rdata_o), .rid_o(rid_o),
    .ad_req_o(ad_req_o), .ad_type_o(ad_type_o), .ad_addr_o(ad_addr_o), .ad_we_o(ad_we_o),
    .ad_wdata_o(ad_wdata_o), .ad_be_o(ad_be_o), .ad_size_o(ad_size_o), .ad_id_o(ad_id_o),
    .ad_gnt_i(ad_gnt_i), .ad_valid_i(ad_valid_i), .ad_rdata_i(ad_rdata_i), .ad_id_i(ad_id_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive point: 1 time unit after the rising edge; checks happen 4 units later (falling edge).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule at transaction level.
  function automatic int predict(input logic [2:0] r, input int ptr);
`ifdef AXI_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 3; k++) if (r[(ptr + k) % 3]) return (ptr + k) % 3;
`else
    for (int p = 0; p < 3; p++) if (r[p]) return p;
`endif
    return -1;
  endfunction

  task automatic rand_port(input int p);
    type_i[p] = 1'($urandom_range(0, 1));
    addr_i[p] = {$urandom, $urandom};
    we_i[p]   = 1'($urandom_range(0, 1));
    for (int b = 0; b < 4; b++) wdata_i[p][b] = {$urandom, $urandom};
    be_i[p]   = $urandom;
    size_i[p] = 2'($urandom_range(0, 3));
    id_i[p]   = 4'($urandom_range(0, 15));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt_o, '0);
    chk({tag, "_valid"}, valid_o, '0);
    chk({tag, "_rdata"}, rdata_o, '0);
    chk({tag, "_rid"}, rid_o, '0);
    chk({tag, "_ad_req"}, ad_req_o, '0);
    chk({tag, "_ad_type"}, ad_type_o, '0);
    chk({tag, "_ad_addr"}, ad_addr_o, '0);
    chk({tag, "_ad_we"}, ad_we_o, '0);
    chk({tag, "_ad_wdata"}, ad_wdata_o, '0);
    chk({tag, "_ad_be"}, ad_be_o, '0);
    chk({tag, "_ad_size"}, ad_size_o, '0);
    chk({tag, "_ad_id"}, ad_id_o, '0);
  endtask

  // One full transaction starting from an IDLE cycle with requests already driven.
  task automatic run_txn(input int lat_g, input int lat_v, input bit vg, input bit mutate,
                         input bit keep, input logic [255:0] rd, input logic [3:0] rid,
                         output int w);
    logic         e_type, e_we;
    logic [63:0]  e_addr;
    logic [255:0] e_wdata;
    logic [31:0]  e_be;
    logic [1:0]   e_size;
    logic [3:0]   e_id;
    logic [2:0]   oh;
    w = predict(req_i, rr_ptr);
    checks++;
    assert (w >= 0) else begin
      errors++;
      $error("FAIL winner: got none expected a requesting port");
    end
    if (w < 0) return;
    e_type = type_i[w]; e_addr = addr_i[w]; e_we = we_i[w]; e_wdata = wdata_i[w];
    e_be = be_i[w]; e_size = size_i[w]; e_id = id_i[w];
    oh = 3'b001 << w;
    #4;
    chk("idle_ad_req", ad_req_o, 1'b0);
    chk("idle_gnt", gnt_o, 3'b000);
    step();
    if (mutate) addr_i[w] = ~addr_i[w];
    for (int i = 0; i < lat_g; i++) begin
      #4;
      chk("req_ad_req", ad_req_o, 1'b1);
      chk("req_ad_addr", ad_addr_o, e_addr);
      chk("req_gnt", gnt_o, 3'b000);
      step();
    end
    ad_gnt_i = 1'b1; ad_valid_i = vg; ad_rdata_i = ~rd; ad_id_i = ~rid;
    #4;
    chk("gnt_onehot", gnt_o, oh);
    chk("gnt_valid_ignored", valid_o, 3'b000);
    chk("gnt_ad_req", ad_req_o, 1'b1);
    chk("ad_type", ad_type_o, e_type);
    chk("ad_addr", ad_addr_o, e_addr);
    chk("ad_we", ad_we_o, e_we);
    chk("ad_wdata", ad_wdata_o, e_wdata);
    chk("ad_be", ad_be_o, e_be);
    chk("ad_size", ad_size_o, e_size);
    chk("ad_id", ad_id_o, e_id);
    step();
    ad_gnt_i = 1'b0; ad_valid_i = 1'b0;
    if (!keep) req_i[w] = 1'b0;
    rr_ptr = (w + 1) % 3;
    for (int i = 0; i < lat_v; i++) begin
      #4;
      chk("wait_valid", valid_o, 3'b000);
      chk("wait_ad_req", ad_req_o, 1'b0);
      chk("wait_gnt", gnt_o, 3'b000);
      step();
    end
    ad_valid_i = 1'b1; ad_rdata_i = rd; ad_id_i = rid;
    #4;
    chk("rsp_valid", valid_o, oh);
    chk("rsp_rdata", rdata_o, rd);
    chk("rsp_rid", rid_o, rid);
    chk("rsp_gnt", gnt_o, 3'b000);
    step();
    ad_valid_i = 1'b0;
  endtask

  initial begin
    int w;
    int exp_seq[6];
    logic [255:0] rd;
    rst_ni = 1'b0; req_i = '0; type_i = '0; addr_i = '0; we_i = '0; wdata_i = '0;
    be_i = '0; size_i = '0; id_i = '0; ad_gnt_i = 1'b0; ad_valid_i = 1'b0;
    ad_rdata_i = '0; ad_id_i = '0;
    #1;
    chk_all_zero("reset");
    step();
    rst_ni = 1'b1;

    // Port 1 cache-line write, grant two cycles after ad_req_o.
    rand_port(1);
    type_i[1] = 1'b1; we_i[1] = 1'b1; addr_i[1] = 64'h0000_0000_8000_0040;
    req_i[1] = 1'b1;
    run_txn(2, 1, 1'b0, 1'b0, 1'b0, {8{32'h1234_5678}}, 4'd3, w);
    chk("t1_winner", 3'(w), 3'd1);

    // Port 0 read with a marker line and id 5; a valid during grant must be ignored.
    rand_port(0);
    we_i[0] = 1'b0;
    req_i[0] = 1'b1;
    run_txn(0, 0, 1'b1, 1'b0, 1'b0, {16'hDEAD, {224{1'b0}}, 16'hBEEF}, 4'd5, w);
    chk("t2_winner", 3'(w), 3'd0);

    // Port 2 changes its address while waiting in REQ.
    rand_port(2);
    req_i[2] = 1'b1;
    run_txn(3, 2, 1'b0, 1'b1, 1'b0, {8{32'hA5A5_0F0F}}, 4'd9, w);
    chk("t3_winner", 3'(w), 3'd2);

    // Reset while in WAIT_RSP.
    rand_port(1);
    req_i[1] = 1'b1;
    step();
    ad_gnt_i = 1'b1;
    step();
    ad_gnt_i = 1'b0; req_i[1] = 1'b0;
    rst_ni = 1'b0; ad_valid_i = 1'b1; ad_rdata_i = {8{32'hFFFF_FFFF}}; ad_id_i = 4'hF;
    #1;
    chk_all_zero("midrst");
    rr_ptr = 0;
    step();
    rst_ni = 1'b1;
    #3;
    chk("postrst_valid", valid_o, 3'b000);
    chk("postrst_rdata", rdata_o, '0);
    step();
    ad_valid_i = 1'b0;
    rand_port(1);
    req_i[1] = 1'b1;
    run_txn(1, 1, 1'b0, 1'b0, 1'b0, {8{32'h0BAD_CAFE}}, 4'd7, w);
    chk("t4_winner", 3'(w), 3'd1);

    // Fresh reset, then all three ports requesting continuously.
    rst_ni = 1'b0;
    rr_ptr = 0;
    step();
    rst_ni = 1'b1;
    for (int p = 0; p < 3; p++) rand_port(p);
    req_i = 3'b111;
`ifdef AXI_ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 2, 0, 1, 2};
`else
    exp_seq = '{0, 0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < 6; i++) begin
      run_txn(i % 2, (i + 1) % 3, 1'b0, 1'b0, 1'b1, {8{$urandom}}, 4'(i), w);
      chk("order", 3'(w), 3'(exp_seq[i]));
    end
    req_i = '0;

    // Random traffic: pending requesters keep their request until granted.
    for (int n = 0; n < 40; n++) begin
      for (int p = 0; p < 3; p++) begin
        if (!req_i[p] && $urandom_range(0, 1) == 1) begin
          rand_port(p);
          req_i[p] = 1'b1;
        end
      end
      if (req_i == 3'b000) begin
        w = $urandom_range(0, 2);
        rand_port(w);
        req_i[w] = 1'b1;
      end
      for (int b = 0; b < 8; b++) rd[b*32 +: 32] = $urandom;
      run_txn($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0, rd, 4'($urandom_range(0, 15)), w);
    end

    req_i = '0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_req_arbiter.md
# axi_req_arbiter

Arbitrates NR_PORTS cache-side request ports (miss handler, bypass, write-back) onto the single request/response interface of the downstream AXI adapter. It registers the winning request and holds it stable until the adapter grants. It then routes the adapter's completion (valid, read line, id) back to the originating port. Exactly one transaction is in flight at a time, matching the adapter's single-outstanding behaviour.

## Interface
- NR_PORTS, 3, number of requesting ports (≥2)
- DATA_WIDTH, 256, cache-line width in bits
- AXI_DATA_WIDTH, 64, AXI beat width; DATA_WIDTH must be a multiple
- AXI_ID_WIDTH, 4, transaction id width
- BEATS (derived), DATA_WIDTH/AXI_DATA_WIDTH
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- req_i  in  NR_PORTS  per-port request
- type_i  in  NR_PORTS×ad_req_t  per-port SINGLE_REQ / CACHE_LINE_REQ
- addr_i  in  NR_PORTS×64  per-port address
- we_i  in  NR_PORTS  per-port write enable
- wdata_i  in  NR_PORTS×DATA_WIDTH  per-port write line (BEATS×AXI_DATA_WIDTH)
- be_i  in  NR_PORTS×DATA_WIDTH/8  per-port byte enables
- size_i  in  NR_PORTS×2  per-port AXI size
- id_i  in  NR_PORTS×AXI_ID_WIDTH  per-port id
- gnt_o  out  NR_PORTS  per-port grant, one-hot or zero
- valid_o  out  NR_PORTS  per-port completion, one-hot or zero
- rdata_o  out  DATA_WIDTH  read line, shared by all ports
- rid_o  out  AXI_ID_WIDTH  completion id, shared
- ad_req_o, ad_type_o, ad_addr_o, ad_we_o, ad_wdata_o, ad_be_o, ad_size_o, ad_id_o  out  matching widths  request to adapter
- ad_gnt_i  in  1  adapter grant
- ad_valid_i  in  1  adapter completion
- ad_rdata_i  in  DATA_WIDTH  adapter read line
- ad_id_i  in  AXI_ID_WIDTH  adapter completion id

## Operation
- FSM states: IDLE, REQ, WAIT_RSP.
- IDLE: if any req_i, select a winner (see Configuration). Latch the winner's type/addr/we/wdata/be/size/id into registers. Store sel_q = winner index, then go to REQ. With no request, stay in IDLE.
- REQ: drive ad_req_o=1 with the latched fields. When ad_gnt_i=1, gnt_o[sel_q]=1 for that cycle and go to WAIT_RSP.
- WAIT_RSP: ad_req_o=0. When ad_valid_i=1, set valid_o[sel_q]=1, rdata_o=ad_rdata_i, rid_o=ad_id_i that cycle, and go to IDLE.
- Requester protocol: hold req_i high until gnt_o. Fields are sampled only in the IDLE cycle that selects the port. Dropping req_i before grant is illegal; the arbiter still completes the latched request.
- Routing uses sel_q, never the id. Ids pass through unchanged.
- Reset, including mid-transaction: state=IDLE, sel_q=0, rr pointer=0, all latched fields 0. The adapter shares the reset, so in-flight work is abandoned.
- Reset values of outputs: gnt_o=0, valid_o=0, ad_req_o=0, rdata_o=0, rid_o=0, all ad_* fields 0.

## Timing
- Arbitration→ad_req_o: 1 cycle. A request at cycle t in IDLE gives ad_req_o at t+1.
- gnt_o and valid_o/rdata_o/rid_o are combinational from ad_gnt_i and ad_valid_i (same cycle).
- All ad_* request outputs are registered and stable throughout REQ.
- After completion at cycle t, re-arbitration happens at t+1 (IDLE) and the next ad_req_o is at t+2. Peak throughput is one transaction per 3 cycles plus adapter latency.
- ad_valid_i in the same cycle as ad_gnt_i (REQ) is ignored. The adapter guarantees valid comes after grant.

## Configuration
- AXI_ARB_ROUND_ROBIN_EN defined: round-robin. The search starts at rr_q, the rr pointer. On each grant, rr_q ← (sel_q+1) mod NR_PORTS, with wrap-around at NR_PORTS-1.
- Undefined: fixed priority, where the lowest requesting index wins. The rr pointer is absent.

## Test plan
- Single port 1 write, CACHE_LINE_REQ, addr 0x8000_0040; ad_gnt_i 2 cycles after ad_req_o -> ad_addr_o=0x8000_0040, ad_we_o=1, gnt_o=3'b010 for exactly one cycle; ad_valid_i -> valid_o=3'b010.
- Port 0 read, ad_rdata_i=0xDEAD…BEEF, ad_id_i=5 -> valid_o=3'b001, rdata_o=0xDEAD…BEEF, rid_o=5 in the same cycle.
- All three ports requesting continuously with round-robin enabled -> grant order 0,1,2,0,1,2. Without the macro -> 0,0,0 (port 0 starves the others).
- Port 2 alters addr_i while waiting in REQ -> ad_addr_o keeps the value latched in IDLE.
- Assert rst_ni in WAIT_RSP -> all outputs 0 immediately. After release, ad_valid_i=1 produces no valid_o, and a new port 1 request is served normally.
